// File: rtl/cereal_pkg.sv
// rtl/cereal_pkg.sv - frame constants and receiver state type shared by both link ends
package cereal_pkg;

  localparam logic START_BIT         = 1'b0;
  localparam logic STOP_BIT          = 1'b1;
  localparam int   DATA_BITS         = 8;
  localparam int   DEFAULT_BIT_TICKS = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/cereal_rx_if.sv
// rtl/cereal_rx_if.sv - FWFT read port between the receiver queue and its consumer
interface cereal_rx_if #(
  parameter int DEPTH = 4
) ();

  logic                     rd;
  logic [7:0]               data;
  logic                     valid;
  logic [$clog2(DEPTH):0]   count;

  modport master (output data, output valid, output count, input rd);
  modport slave  (input data, input valid, input count, output rd);

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through queue holding received bytes
module sync_fifo
  import cereal_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_BITS
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             pop;
  logic             push;

  assign valid   = (count_q != '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop     = rd && valid;
  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign push    = wr_en && (!full || pop);
  assign rd_data = valid ? mem[rd_ptr] : '0;
  assign count   = count_q;

  // Storage write; stale entries are never visible because rd_data is masked when empty
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/cereal_rx.sv
// rtl/cereal_rx.sv - serial frame receiver feeding a small FWFT queue
module cereal_rx
  import cereal_pkg::*;
#(
  parameter int BIT_TICKS = DEFAULT_BIT_TICKS,
  parameter int DEPTH     = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        serialIn,
  cereal_rx_if.master rxq,
  output logic        busy,
  output logic        frame_err,
  output logic        overflow
);

  localparam int                CW        = $clog2(BIT_TICKS);
  localparam int                BW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0]     FULL_LAST = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0]     HALF_LAST = CW'(BIT_TICKS / 2 - 1);

  rx_state_t              state;
  rx_state_t              state_n;
  logic                   sync_a;
  logic                   sync_b;
  logic                   line_d;
  logic                   line;
  logic                   fall;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   tick_done;
  logic                   cnt_clr;
  logic                   shift_en;
  logic                   push;
  logic                   ferr_set;
  logic                   full;
  logic                   drop;

  assign line = sync_b;
  assign fall = line_d && !sync_b;
  assign busy = (state != IDLE);
  // The first sample lands mid start bit; every later one is a whole bit apart.
  assign tick_done = (state == START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);
  assign drop = push && full && !rxq.rd;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      line_d <= 1'b1;
    end else begin
      sync_a <= serialIn;
      sync_b <= sync_a;
      line_d <= sync_b;
    end
  end

  // Receiver state register
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (fall) state_n = START;
      end
      START: begin
        if (tick_done) begin
          cnt_clr = 1'b1;
          state_n = (line == START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (tick_done) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == BW'(DATA_BITS - 1)) state_n = STOP;
        end
      end
      STOP: begin
        if (tick_done) begin
          cnt_clr = 1'b1;
          if (line == STOP_BIT) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_clr = 1'b1;
        if (line) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit timer, shift register, error pulse and sticky overflow
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (shift_en) begin
        shreg   <= {line, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + BW'(1);
      end else if (state != DATA) begin
        bit_idx <= '0;
      end
      frame_err <= ferr_set;
      if (drop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .sysclk  (sysclk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (shreg),
    .rd      (rxq.rd),
    .rd_data (rxq.data),
    .valid   (rxq.valid),
    .full    (full),
    .count   (rxq.count)
  );

endmodule

// File: tb/tb_cereal_rx.sv
// tb/tb_cereal_rx.sv - self-checking bench for cereal_rx
module tb_cereal_rx;

  localparam int BT    = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] din;
    logic       stop_ok;
    logic       do_pop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_count;
    int         exp_ferr;
  } vec_t;

  logic sysclk = 1'b0;
  logic reset = 1'b0;
  logic serialIn = 1'b1;
  logic busy;
  logic frame_err;
  logic overflow;

  int errors = 0;
  int checks = 0;
  int ferr_cycles = 0;

  cereal_rx_if #(.DEPTH(DEPTH)) rxq ();

  cereal_rx #(
    .BIT_TICKS (BT),
    .DEPTH     (DEPTH)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .serialIn  (serialIn),
    .rxq       (rxq),
    .busy      (busy),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) begin
    if (frame_err === 1'b1) ferr_cycles++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic align();
    @(posedge sysclk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serialIn = b;
    repeat (BT) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    @(negedge sysclk);
    chk({name, " valid"}, rxq.valid, 1);
    chk({name, " data"}, rxq.data, exp);
    rxq.rd = 1'b1;
    @(posedge sysclk);
    #1;
    rxq.rd = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " data"}, rxq.data, 0);
    chk({tag, " valid"}, rxq.valid, 0);
    chk({tag, " count"}, rxq.count, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " frame_err"}, frame_err, 0);
    chk({tag, " overflow"}, overflow, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    serialIn = 1'b1;
    rxq.rd = 1'b0;
    repeat (3) align();
    reset = 1'b1;
    align();
  endtask

  vec_t vecs[6];
  logic [7:0] model_q[$];
  logic exp_ovf;
  int base;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 3'd1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 3'd2, 0};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h00, 3'd3, 0};
    vecs[5] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'hFF, 3'd3, 0};

    rxq.rd = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    chk_reset_vals("por");
    reset = 1'b1;
    align();

    // Single byte with edge-to-busy latency and stop-bit timing
    align();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        chk("single busy_e2", busy, 0);
        @(posedge sysclk);
        @(negedge sysclk);
        chk("single busy_e3", busy, 1);
        repeat (147) @(posedge sysclk);
        @(negedge sysclk);
        chk("single valid_in_stop", rxq.valid, 0);
      end
    join
    @(negedge sysclk);
    chk("single count", rxq.count, 1);
    pop_chk("single", 8'hA5);
    @(negedge sysclk);
    chk("single empty", rxq.valid, 0);

    // Glitch shorter than half a bit
    align();
    base = ferr_cycles;
    serialIn = 1'b0;
    repeat (5) align();
    chk("glitch busy", busy, 1);
    serialIn = 1'b1;
    repeat (20) align();
    chk("glitch idle", busy, 0);
    chk("glitch valid", rxq.valid, 0);
    chk("glitch ferr", ferr_cycles - base, 0);

    // Table of frames
    for (int i = 0; i < 6; i++) begin
      base = ferr_cycles;
      send_frame(vecs[i].din, vecs[i].stop_ok);
      if (!vecs[i].stop_ok) begin
        repeat (20) align();
        serialIn = 1'b1;
      end
      repeat (6) align();
      @(negedge sysclk);
      chk($sformatf("vec%0d valid", i), rxq.valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d count", i), rxq.count, vecs[i].exp_count);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d data", i), rxq.data, vecs[i].exp_data);
      chk($sformatf("vec%0d ferr", i), ferr_cycles - base, vecs[i].exp_ferr);
      chk($sformatf("vec%0d busy", i), busy, 0);
      if (vecs[i].do_pop) pop_chk($sformatf("vec%0d pop", i), vecs[i].exp_data);
    end
    pop_chk("drain0", 8'hFF);
    pop_chk("drain1", 8'h81);
    pop_chk("drain2", 8'h5A);

    // Framing error with line held low, then recovery
    do_reset();
    base = ferr_cycles;
    send_frame(8'h3C, 1'b0);
    repeat (40) align();
    chk("ferr held busy", busy, 1);
    serialIn = 1'b1;
    repeat (5) align();
    chk("ferr idle", busy, 0);
    chk("ferr not queued", rxq.valid, 0);
    send_frame(8'h81, 1'b1);
    repeat (2) align();
    chk("ferr pulses", ferr_cycles - base, 1);
    chk("ferr next count", rxq.count, 1);
    pop_chk("ferr next", 8'h81);

    // Overflow on five back-to-back frames
    do_reset();
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    repeat (2) align();
    chk("ovf count", rxq.count, 4);
    chk("ovf flag", overflow, 1);
    for (int k = 1; k <= 4; k++) pop_chk($sformatf("ovf pop%0d", k), 8'(k));
    @(negedge sysclk);
    chk("ovf empty", rxq.valid, 0);
    chk("ovf sticky", overflow, 1);

    // Full queue with a pop in the push cycle
    do_reset();
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1);
    repeat (2) align();
    chk("fullrd pre count", rxq.count, 4);
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (154) @(posedge sysclk);
        #1 rxq.rd = 1'b1;
        @(posedge sysclk);
        #1 rxq.rd = 1'b0;
      end
    join
    @(negedge sysclk);
    chk("fullrd count", rxq.count, 4);
    chk("fullrd overflow", overflow, 0);
    pop_chk("fullrd pop0", 8'h02);
    pop_chk("fullrd pop1", 8'h03);
    pop_chk("fullrd pop2", 8'h04);
    pop_chk("fullrd pop3", 8'h55);
    @(negedge sysclk);
    chk("fullrd empty", rxq.valid, 0);

    // Reset during data bit 3
    do_reset();
    send_frame(8'h11, 1'b1);
    repeat (2) align();
    chk("midrst pre valid", rxq.valid, 1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    serialIn = 1'b0;
    repeat (5) align();
    chk("midrst busy", busy, 1);
    reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    serialIn = 1'b1;
    repeat (3) align();
    reset = 1'b1;
    repeat (5) align();
    chk("midrst idle", busy, 0);
    send_frame(8'h7E, 1'b1);
    repeat (2) align();
    chk("midrst count", rxq.count, 1);
    chk("midrst overflow", overflow, 0);
    pop_chk("midrst 7E", 8'h7E);

    // Random frames against a queue model
    do_reset();
    model_q.delete();
    exp_ovf = 1'b0;
    for (int it = 0; it < 24; it++) begin
      logic [7:0] b;
      logic good;
      int npop;
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 7) != 0);
      base = ferr_cycles;
      send_frame(b, good);
      if (!good) begin
        repeat ($urandom_range(1, 30)) align();
        serialIn = 1'b1;
      end
      repeat (6) align();
      if (good) begin
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else exp_ovf = 1'b1;
      end
      @(negedge sysclk);
      chk($sformatf("rnd%0d count", it), rxq.count, model_q.size());
      chk($sformatf("rnd%0d valid", it), rxq.valid, model_q.size() != 0);
      chk($sformatf("rnd%0d overflow", it), overflow, exp_ovf);
      chk($sformatf("rnd%0d ferr", it), ferr_cycles - base, good ? 0 : 1);
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++) begin
        if (model_q.size() > 0) begin
          pop_chk($sformatf("rnd%0d pop%0d", it, j), model_q.pop_front());
        end else begin
          rxq.rd = 1'b1;
          align();
          rxq.rd = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cereal_rx.md
# cereal_rx

Serial receiver for the board-to-board link. Consumes the single-wire stream that the switchboard drives out (`out_final_really`), recovers 8-bit frames, and queues them in a small first-word-fall-through FIFO for a downstream consumer, e.g. tweetboard storage or an LED display. It is the receive counterpart of `cereal` and defines the line format for both ends.

## Interface
- `BIT_TICKS`, 868: sysclk cycles per bit (100 MHz / 115200); must be ≥ 4.
- `DEPTH`, 4: FIFO entries, power of two.
- `sysclk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `serialIn`  in  1  asynchronous serial line, idle high.
- `rd`  in  1  pop the head entry; ignored when `valid`=0.
- `data`  out  8  head FIFO entry; valid only while `valid`=1.
- `valid`  out  1  FIFO non-empty.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `busy`  out  1  receiver not in IDLE.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `overflow`  out  1  sticky; a completed frame was dropped because the FIFO was full.

## Operation
- Line format: idle 1, start bit 0, 8 data bits LSB first, stop bit 1, each bit `BIT_TICKS` cycles.
- `serialIn` passes a 2-flop synchronizer. Edge detection and sampling use only the synchronized signal.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a synchronized 1→0 transition starts the bit counter and enters START.
  - START: at `BIT_TICKS/2` cycles (integer divide), sample the line. If 0, go to DATA and reload the counter. If 1, treat it as a glitch and return to IDLE with no output.
  - DATA: sample every `BIT_TICKS` cycles and shift into bit [7] of the shift register, right-shifting. After 8 samples go to STOP.
  - STOP: sample after `BIT_TICKS` cycles.
    - Sample 1: push the byte and return to IDLE.
    - Sample 0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronized line is 1, then go to IDLE. This prevents re-triggering on a held-low line.
- FIFO write rules:
  - Full with no `rd` in the same cycle: the byte is dropped and `overflow` is set.
  - Full with `rd` in the same cycle: the pop and the push both succeed, and `count` is unchanged.
- FIFO read: `rd` with `valid`=1 advances the head. `rd` while empty has no effect.
- Pointers wrap modulo `DEPTH`. `count` is the write count minus the read count, and saturates at neither end because the rules above prevent overrun.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: `data`=0, `valid`=0, `count`=0, `busy`=0, `frame_err`=0, `overflow`=0, FSM in IDLE, pointers 0.
- Reset mid-frame aborts the frame immediately. After release the receiver waits in IDLE for the next falling edge.
- Latency from the line's falling edge to IDLE leaving: 3 cycles (2 for the synchronizer, 1 for edge detect).
- Stop-bit sample to byte available: the push happens in the sample cycle. `valid`, `data` and `count` update on the next rising edge.
- `rd` takes effect on the rising edge. The next head entry, or `valid`=0, is visible the following cycle.
- `frame_err` is high for exactly the cycle after the failing stop sample.
- `overflow` is cleared only by reset.

## Structure
- Shared package `cereal_pkg` holds:
  - the FSM state typedef;
  - the frame constants START_BIT=0, STOP_BIT=1 and DATA_BITS=8;
  - the default `BIT_TICKS`.
- `cereal` imports the same package so both ends agree on the frame.
- One sub-module, `sync_fifo`, contains the FWFT storage, pointers, `count` and the full/empty logic.

## Test plan
- Use `BIT_TICKS`=16 and `DEPTH`=4 throughout.
- Single byte: send 0xA5 → 3 cycles later `busy`=1; `valid`=1 with `data`=0xA5 and `count`=1 one cycle after the stop sample; `rd` → `valid`=0.
- Glitch: drive the line low for 5 cycles, then high → FSM returns to IDLE, `valid` stays 0, `frame_err` stays 0.
- Framing error: send 0x3C with stop bit 0, hold low 40 cycles, then send 0x81 → one `frame_err` pulse; 0x3C never queued; 0x81 received after the line returns high.
- Overflow: send 0x01–0x05 back-to-back without `rd` → `count`=4, `overflow`=1; popping yields 0x01, 0x02, 0x03, 0x04.
- Full with simultaneous read: FIFO full; assert `rd` in the push cycle of a fifth byte 0x55 → `overflow` stays 0, `count` stays 4, 0x55 is last out.
- Reset mid-frame: assert `reset` low during DATA bit 3 → all outputs at reset values; a following frame 0x7E is received correctly.
